// File: rtl/golden_nonce_queue_pkg.sv
// Shared miner constants and types used by the golden-nonce reporting path.
package golden_nonce_queue_pkg;

  localparam int NONCE_W       = 32;
  localparam int DEFAULT_DEPTH = 8;
  localparam int DEFAULT_CNT_W = 8;

  typedef logic [NONCE_W-1:0] nonce_t;

endpackage

// File: rtl/golden_nonce_ram.sv
// Storage array for the golden-nonce queue: one write port, asynchronous read, no reset.
module golden_nonce_ram
  import golden_nonce_queue_pkg::*;
#(
  parameter int DEPTH = DEFAULT_DEPTH
) (
  input  logic                     clk_i,
  input  logic                     we_i,
  input  logic [$clog2(DEPTH)-1:0] waddr_i,
  input  logic [NONCE_W-1:0]       wdata_i,
  input  logic [$clog2(DEPTH)-1:0] raddr_i,
  output logic [NONCE_W-1:0]       rdata_o
);

  nonce_t mem_q [DEPTH];

  // Write port; contents are never cleared, the queue masks stale entries.
  always_ff @(posedge clk_i) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/golden_nonce_queue.sv
// First-word-fall-through queue buffering golden nonces from the hash core
// for the host, with sticky overflow flag and saturating drop counter.
module golden_nonce_queue
  import golden_nonce_queue_pkg::*;
#(
  parameter int DEPTH = DEFAULT_DEPTH,
  parameter int CNT_W = DEFAULT_CNT_W
) (
  input  logic                     hash_clk,
  input  logic                     reset,
  input  logic [NONCE_W-1:0]       golden_nonce,
  input  logic                     golden_nonce_match,
  input  logic                     pop,
  output logic [NONCE_W-1:0]       dout,
  output logic                     dout_valid,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     overflow,
  output logic [CNT_W-1:0]         drop_count,
  input  logic                     clear_overflow
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CW    = PTR_W + 1;
  localparam logic [CW-1:0]    FULL_CNT = CW'(DEPTH);
  localparam logic [CW-1:0]    ZERO_CNT = {CW{1'b0}};
  localparam logic [CNT_W-1:0] DROP_MAX = {CNT_W{1'b1}};

  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic             dout_valid_q, dout_valid_d;
  logic             overflow_q, overflow_d;
  logic [CNT_W-1:0] drop_count_q, drop_count_d;

  logic   pop_ok_s;
  logic   push_ok_s;
  logic   drop_s;
  logic   we_s;
  nonce_t rd_data_s;

  // A pop on a full queue frees the slot the same-cycle push lands in.
  assign pop_ok_s  = pop && (count_q != ZERO_CNT);
  assign push_ok_s = golden_nonce_match && ((count_q != FULL_CNT) || pop_ok_s);
  assign drop_s    = golden_nonce_match && !push_ok_s;
  assign we_s      = push_ok_s && !reset;

  golden_nonce_ram #(
    .DEPTH (DEPTH)
  ) u_ram (
    .clk_i   (hash_clk),
    .we_i    (we_s),
    .waddr_i (wr_ptr_q),
    .wdata_i (golden_nonce),
    .raddr_i (rd_ptr_q),
    .rdata_o (rd_data_s)
  );

  // Next-state for pointers, occupancy and overflow bookkeeping.
  always_comb begin
    wr_ptr_d     = wr_ptr_q;
    rd_ptr_d     = rd_ptr_q;
    count_d      = count_q;
    overflow_d   = overflow_q;
    drop_count_d = drop_count_q;

    if (push_ok_s) begin
      wr_ptr_d = wr_ptr_q + PTR_W'(1);
    end else begin
      wr_ptr_d = wr_ptr_q;
    end

    if (pop_ok_s) begin
      rd_ptr_d = rd_ptr_q + PTR_W'(1);
    end else begin
      rd_ptr_d = rd_ptr_q;
    end

    if (push_ok_s && !pop_ok_s) begin
      count_d = count_q + CW'(1);
    end else if (pop_ok_s && !push_ok_s) begin
      count_d = count_q - CW'(1);
    end else begin
      count_d = count_q;
    end

    // Clearing wins over a drop in the same cycle.
    if (clear_overflow) begin
      overflow_d   = 1'b0;
      drop_count_d = {CNT_W{1'b0}};
    end else if (drop_s) begin
      overflow_d   = 1'b1;
      drop_count_d = (drop_count_q == DROP_MAX) ? drop_count_q : drop_count_q + CNT_W'(1);
    end else begin
      overflow_d   = overflow_q;
      drop_count_d = drop_count_q;
    end

    dout_valid_d = (count_d != ZERO_CNT);
  end

  // State registers; reset overrides every same-cycle request.
  always_ff @(posedge hash_clk) begin
    if (reset) begin
      wr_ptr_q     <= {PTR_W{1'b0}};
      rd_ptr_q     <= {PTR_W{1'b0}};
      count_q      <= ZERO_CNT;
      dout_valid_q <= 1'b0;
      overflow_q   <= 1'b0;
      drop_count_q <= {CNT_W{1'b0}};
    end else begin
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      count_q      <= count_d;
      dout_valid_q <= dout_valid_d;
      overflow_q   <= overflow_d;
      drop_count_q <= drop_count_d;
    end
  end

  assign dout       = dout_valid_q ? rd_data_s : {NONCE_W{1'b0}};
  assign dout_valid = dout_valid_q;
  assign count      = count_q;
  assign overflow   = overflow_q;
  assign drop_count = drop_count_q;

endmodule

// File: doc/golden_nonce_queue.md
GOLDEN_NONCE_QUEUE -- requirements
Module: golden_nonce_queue

Interface
REQ-001 SHALL have parameter DEPTH, default 8, FIFO entries, power of two, range 2..64.
REQ-002 SHALL have parameter CNT_W, default 8, width of drop counter.
REQ-003 SHALL have port hash_clk  input  1  sole clock, all logic on rising edge.
REQ-004 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-005 SHALL have port golden_nonce  input  32  candidate nonce from hash core.
REQ-006 SHALL have port golden_nonce_match  input  1  one-cycle strobe qualifying golden_nonce.
REQ-007 SHALL have port pop  input  1  host consumes head entry.
REQ-008 SHALL have port dout  output  32  head entry, first-word-fall-through.
REQ-009 SHALL have port dout_valid  output  1  queue non-empty.
REQ-010 SHALL have port count  output  $clog2(DEPTH)+1  current occupancy.
REQ-011 SHALL have port overflow  output  1  sticky, set when a push is dropped.
REQ-012 SHALL have port drop_count  output  CNT_W  dropped-push counter, saturating.
REQ-013 SHALL have port clear_overflow  input  1  clears overflow and drop_count.

Function
REQ-014 SHALL push golden_nonce on any cycle golden_nonce_match=1 and the push is accepted.
REQ-015 SHALL make a pushed entry visible on dout/dout_valid one cycle after the strobe, never combinationally.
REQ-016 SHALL present the oldest entry on dout whenever dout_valid=1; dout = 0 when empty.
REQ-017 SHALL remove the head on pop=1 with dout_valid=1; next entry appears on dout the following cycle.
REQ-018 SHALL ignore pop when empty: no pointer, count or flag change.
REQ-019 SHALL accept push and pop together when not full and not empty: count unchanged, order preserved.
REQ-020 SHALL accept push and pop together when full: pop frees the slot, push stored, no overflow.
REQ-021 SHALL accept push and pop together when empty: push stored, pop ignored, count becomes 1.
REQ-022 SHALL, on push when full without pop, drop the nonce, leave contents intact, set overflow, increment drop_count.
REQ-023 SHALL saturate drop_count at 2^CNT_W-1, never wrapping.
REQ-024 SHALL give clear_overflow priority over a same-cycle drop: overflow=0, drop_count=0 afterwards.
REQ-025 SHALL wrap read/write pointers modulo DEPTH; full/empty distinguished by count, not pointer equality alone.
REQ-026 SHALL keep count in 0..DEPTH at all times.

Reset
REQ-027 SHALL, with reset=1 at a clock edge, set count=0, pointers=0, dout_valid=0, dout=0, overflow=0, drop_count=0.
REQ-028 SHALL give reset priority over push, pop and clear_overflow in the same cycle; a strobe during reset is discarded.
REQ-029 SHALL need no storage-array clear on reset; stale data is never visible because dout_valid=0 masks it.
REQ-030 SHALL accept a push on the first cycle after reset deasserts.

Structure
REQ-031 SHALL take NONCE_W=32 and the default DEPTH/CNT_W constants from the shared miner package.
REQ-032 SHALL isolate storage in one sub-module, golden_nonce_ram: DEPTH x 32, single write port, asynchronous read, no reset.
REQ-033 SHALL keep pointers, count and flag logic in golden_nonce_queue; no other sub-modules.

Verification
REQ-034 SHALL cover single push: strobe with 0x0000ABCD -> next cycle dout=0x0000ABCD, dout_valid=1, count=1; pop -> next cycle dout_valid=0, count=0.
REQ-035 SHALL cover order and wrap: 12 pushes/pops interleaved, 0x1..0xC, DEPTH=8 -> popped sequence 0x1..0xC exactly.
REQ-036 SHALL cover overflow: 10 strobes with no pop, DEPTH=8 -> count=8, overflow=1, drop_count=2, entries are the first 8 values; clear_overflow -> overflow=0, drop_count=0, count=8.
REQ-037 SHALL cover full with simultaneous push and pop: fill 8, then strobe 0x99 with pop -> count=8, overflow=0, 0x99 read out last.
REQ-038 SHALL cover reset mid-operation: 5 entries queued, reset pulse with same-cycle strobe -> next cycle count=0, dout_valid=0, overflow=0; later push 0x7 reads back 0x7.
REQ-039 SHALL cover pop on empty plus CNT_W=2 saturation: pop on empty -> no change; 6 drops -> drop_count=3.
